// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with live water level, programmable almost flags,
// optional first-word-fall-through read port and overflow/underflow pulses.
module sync_fifo_wl #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 12,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int LW    = DEPTH_WIDTH + 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_ovalid;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_afull;
  logic                   r_aempty;
  logic                   r_ovf;
  logic                   r_udf;
  logic [DATA_WIDTH-1:0]  r_rd_data;

  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_load;
  logic                   w_ovalid_next;
  logic                   w_empty_next;
  logic [LW-1:0]          w_level_next;
  logic [LW-1:0]          w_ram_cnt;

  always_comb begin
    w_wr_ok       = wr_en & ~r_full;
    w_rd_ok       = rd_en & ~r_empty;
    w_level_next  = r_level + LW'(w_wr_ok) - LW'(w_rd_ok);
    w_ram_cnt     = r_level - LW'(r_ovalid);
    w_load        = w_rd_ok;
    w_ovalid_next = 1'b0;
    w_empty_next  = (w_level_next == '0);
    // FWFT: the output register counts toward the level; it is refilled
    // from RAM whenever it is vacant or being consumed this edge.
    if (FWFT != 0) begin
      w_load        = (w_ram_cnt != '0) & (~r_ovalid | w_rd_ok);
      w_ovalid_next = w_load | (r_ovalid & ~w_rd_ok);
      w_empty_next  = ~w_ovalid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovalid  <= 1'b0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_level  <= w_level_next;
      r_ovalid <= w_ovalid_next;
      r_full   <= (w_level_next == LVL_FULL);
      r_empty  <= w_empty_next;
      r_afull  <= (int'(w_level_next) >= ALMOST_FULL_NUM);
      r_aempty <= (int'(w_level_next) <= ALMOST_EMPTY_NUM);
      r_ovf    <= wr_en & r_full;
      r_udf    <= rd_en & r_empty;
    end
  end

  assign wr_full      = r_full;
  assign almost_full  = r_afull;
  assign rd_empty     = r_empty;
  assign almost_empty = r_aempty;
  assign water_level  = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign rd_data      = r_rd_data;

endmodule
